// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: shares one memory port between a loader
// (writes) and an instruction fetcher (reads) with round-robin tie breaking.
module imem_arbiter #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_req,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_lock,
   output logic              ld_gnt,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_valid,
   output logic [DATA_W-1:0] f_data,
   output logic              we_IM,
   output logic [ADDR_W-1:0] addIM,
   output logic [DATA_W-1:0] dataIM,
   input  logic [DATA_W-1:0] outIM,
   output logic [ADDR_W:0]   ld_cnt,
   output logic              busy
);

   localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, WR, RD, RDW} state_t;

   state_t state, state_next;
   logic   pri;
   logic   elig_ld, elig_f, contested;

   always_comb begin
      state_next = state;
      ld_gnt     = 1'b0;
      f_gnt      = 1'b0;
      elig_ld    = ld_req & ~ld_lock;
      elig_f     = f_req;
      contested  = 1'b0;
      case (state)
         IDLE: begin
            // rst gating keeps grants low while the async reset is held
            if (!rst) begin
               contested = elig_ld & elig_f;
               if (contested) begin
                  ld_gnt = pri;
                  f_gnt  = ~pri;
               end else begin
                  ld_gnt = elig_ld;
                  f_gnt  = elig_f;
               end
            end
            if (ld_gnt)
               state_next = WR;
            else if (f_gnt)
               state_next = RD;
         end
         WR:      state_next = IDLE;
         RD:      state_next = RDW;
         RDW:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pri     <= 1'b0;
         we_IM   <= 1'b0;
         addIM   <= '0;
         dataIM  <= '0;
         f_valid <= 1'b0;
         f_data  <= '0;
         ld_cnt  <= '0;
      end else begin
         state <= state_next;
         if (contested)
            pri <= ~pri;
         we_IM <= ld_gnt;
         if (ld_gnt) begin
            addIM  <= ld_addr;
            dataIM <= ld_data;
         end else if (f_gnt) begin
            addIM <= f_addr;
         end
         // memory read data for the address presented in RD is on outIM in RDW
         f_valid <= (state == RDW);
         if (state == RDW)
            f_data <= outIM;
         if (ld_gnt && (ld_cnt != CNT_MAX))
            ld_cnt <= ld_cnt + 1'b1;
      end
   end

   assign busy = (state != IDLE);

endmodule
